// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC with exception/ERET update.
// Optional Count/Compare timer interrupt enabled by defining CP0_TIMER_INT_EN.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic        is_except_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tog_q, tog_d;
    logic        exc_known, exc_eret, exc_addr;
    logic [4:0]  exc_code;

    always_comb begin
        exc_known = 1'b0;
        exc_eret  = 1'b0;
        case (except_type_i)
            32'h1, 32'h4, 32'h5, 32'h8,
            32'h9, 32'hA, 32'hC: exc_known = 1'b1;
            32'hE:               exc_eret  = 1'b1;
            default: ;
        endcase
    end

    assign exc_addr = (except_type_i == 32'h4) || (except_type_i == 32'h5);
    // Interrupt cause is reported as ExcCode 0
    assign exc_code = (except_type_i == 32'h1) ? 5'd0 : except_type_i[4:0];

    always_comb begin
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        badv_d    = badv_q;
        compare_d = compare_q;
        tog_d     = ~tog_q;
        count_d   = tog_q ? count_q + 32'd1 : count_q;
        cause_d[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
        if (is_except_i) begin
            if (exc_eret) begin
                status_d[1] = 1'b0;
            end else if (exc_known) begin
                if (!status_q[1]) begin
                    epc_d       = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    cause_d[31] = in_delayslot_i;
                    status_d[1] = 1'b1;
                end
                cause_d[6:2] = exc_code;
                if (exc_addr) badv_d = bad_addr_i;
            end
        end else if (we_i) begin
            case (waddr_i)
                5'd9: begin
                    count_d = wdata_i;
                    tog_d   = 1'b0;
                end
                5'd11: compare_d = wdata_i;
                5'd12: status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                5'd13: cause_d[9:8] = wdata_i[9:8];
                5'd14: epc_d = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= STATUS_RST;
            cause_q   <= '0;
            epc_q     <= '0;
            badv_q    <= '0;
            count_q   <= '0;
            compare_q <= '0;
            tog_q     <= 1'b0;
        end else begin
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            badv_q    <= badv_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            tog_q     <= tog_d;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic timer_q;
    logic cmp_wr;
    assign cmp_wr = we_i && !is_except_i && (waddr_i == 5'd11);
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 1'b0;
        end else if (cmp_wr) begin
            timer_q <= 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            timer_q <= 1'b1;
        end
    end
    assign timer_int_o = timer_q;
`else
    assign timer_int_o = 1'b0;
`endif

    always_comb begin
        case (raddr_i)
            5'd8:    rdata_o = badv_q;
            5'd9:    rdata_o = count_q;
            5'd11:   rdata_o = compare_q;
            5'd12:   rdata_o = status_q;
            5'd13:   rdata_o = cause_q;
            5'd14:   rdata_o = epc_q;
            default: rdata_o = 32'd0;
        endcase
    end

    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;
endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL expose parameter STATUS_RST, default 32'h0040_0000, meaning the Status reset value (BEV=1, IM=0, EXL=0, IE=0).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  rising-edge clock
  rst  in  1  reset rst, synchronous, active-high
  we_i  in  1  MTC0 write enable
  waddr_i  in  5  MTC0 register number
  wdata_i  in  32  MTC0 write data
  raddr_i  in  5  MFC0 register number
  rdata_o  out  32  MFC0 read data
  int_i  in  6  hardware interrupt lines
  is_except_i  in  1  exception/ERET taken this cycle (from exception decoder)
  except_type_i  in  32  encoded cause: 1 int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 0xA RI, 0xC Ov, 0xE ERET
  pc_i  in  32  PC of the M-stage instruction
  in_delayslot_i  in  1  M-stage instruction is in a branch delay slot
  bad_addr_i  in  32  faulting address for AdEL/AdES
  status_o / cause_o / epc_o  out  32 each  live register values
  timer_int_o  out  1  Count/Compare timer interrupt pending

Function
REQ-003 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other numbers read 0, writes ignored.
REQ-004 rdata_o SHALL be combinational from raddr_i and current register state; no same-cycle write bypass.
REQ-005 MTC0 writable bits: Status IM[15:8], EXL[1], IE[0] (BEV[22] read-only 1, others 0); Cause IP[9:8] only; Count, Compare, EPC all 32 bits; BadVAddr read-only.
REQ-006 Cause.IP[7:2] SHALL sample int_i every cycle (IP[7] = int_i[5] | timer_int_o when timer compiled in), visible next cycle.
REQ-007 Count SHALL increment by 1 every second clock via an internal toggle flop; wrap 32'hFFFF_FFFF -> 0; MTC0 to Count loads wdata_i and resets the toggle.
REQ-008 On is_except_i with type != 0xE and Status.EXL=0: EPC <= in_delayslot_i ? pc_i-4 : pc_i; Cause.BD <= in_delayslot_i; Status.EXL <= 1; Cause.ExcCode[6:2] <= code (1 maps to 0, others equal type[4:0]).
REQ-009 Same as REQ-008 but Status.EXL=1: only ExcCode updated; EPC and BD unchanged.
REQ-010 Types 4 and 5 SHALL also load BadVAddr <= bad_addr_i.
REQ-011 Type 0xE (ERET) SHALL clear Status.EXL only.
REQ-012 is_except_i and we_i in same cycle: exception update wins, MTC0 discarded entirely.
REQ-013 Unknown except_type_i with is_except_i=1 SHALL change no register.
REQ-014 epc_o/status_o/cause_o SHALL reflect registered values (one-cycle latency after update).

Reset
REQ-015 On rst: Status=STATUS_RST, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, toggle=0, timer_int_o=0; rst overrides all same-cycle events.
REQ-016 rst asserted mid-operation SHALL discard any pending exception/MTC0 update that cycle.

Configuration
REQ-017 Macro CP0_TIMER_INT_EN defined: timer_int_o set when Count==Compare and Compare!=0, held until MTC0 to Compare, OR-ed into Cause.IP[7].
REQ-018 Macro undefined: timer_int_o tied 0, Count/Compare still read/writable, IP[7]=int_i[5] only.

Verification
REQ-019 rst 1 cycle -> status_o=32'h0040_0000, cause_o=0, epc_o=0, timer_int_o=0.
REQ-020 is_except_i=1, type=8, pc_i=32'hBFC0_1004, delayslot=1, EXL=0 -> next cycle epc_o=32'hBFC0_1000, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
REQ-021 type=4, bad_addr_i=32'h8000_0003 -> BadVAddr reads 32'h8000_0003, ExcCode=4; then type=0xE -> status_o[1]=0, epc_o unchanged.
REQ-022 we_i to Status with is_except_i(type 0xC) same cycle -> Status gets only EXL=1, IM unchanged.
REQ-023 (CP0_TIMER_INT_EN) write Compare=10, Count=0 -> timer_int_o rises after 20 cycles, cause_o[15]=1; MTC0 Compare clears it.
REQ-024 MTC0 Count=32'hFFFF_FFFF -> reads 0 two cycles later.
